// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scan driver with a sequential shift-add-3 binary-to-BCD converter.
// Optional leading-zero blanking is enabled by defining DISPLAY_BLANK_EN.
module display_scan_controller #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 16,
   parameter int DIV    = 50000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  valor,
   input  logic              carregar,
   output logic              ocupado,
   output logic              estouro,
   output logic [3:0]        digito,
   output logic [DIGITS-1:0] anodo
);

   localparam int NB = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW = $clog2(WIDTH);

   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);
   localparam logic [TW-1:0] ITER_LAST  = TW'(WIDTH - 1);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   // Overflow is decided once at capture time against this constant.
   localparam logic [63:0]   LIMIT     = pow10(DIGITS);
   localparam logic [NB-1:0] ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [NB-1:0]     acc_q, acc_d;
   logic [TW-1:0]     iter_q, iter_d;
   logic              ovf_q, ovf_d;
   logic              estouro_q, estouro_d;
   logic [NB-1:0]     disp_q, disp_d;
   logic [CW-1:0]     presc_q, presc_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [3:0]        digito_q, digito_d;
   logic [DIGITS-1:0] anodo_q, anodo_d;
   logic [NB-1:0]     adj;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      acc_d     = acc_q;
      iter_d    = iter_q;
      ovf_d     = ovf_q;
      estouro_d = estouro_q;
      disp_d    = disp_q;
      adj       = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      case (state_q)
         OCIOSO: begin
            if (carregar) begin
               shift_d = valor;
               acc_d   = '0;
               iter_d  = '0;
               ovf_d   = (64'(valor) >= LIMIT);
               state_d = CONVERTE;
            end
         end
         CONVERTE: begin
            // Carry out of the top nibble is dropped; overflow is already known.
            acc_d   = {adj[NB-2:0], shift_q[WIDTH-1]};
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            iter_d  = iter_q + TW'(1);
            if (iter_q == ITER_LAST) state_d = ATUALIZA;
         end
         ATUALIZA: begin
            disp_d    = ovf_q ? ALL_NINES : acc_q;
            estouro_d = ovf_q;
            state_d   = OCIOSO;
         end
         default: state_d = OCIOSO;
      endcase
   end

   always_comb begin
      logic [3:0] nib;
`ifdef DISPLAY_BLANK_EN
      logic       above_zero;
      above_zero = 1'b1;
`endif
      nib      = 4'h0;
      digito_d = 4'h0;
      presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + CW'(1);
      idx_d    = idx_q;
      if (presc_q == PRESC_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      anodo_d  = ~(DIGITS'(1) << idx_d);
      // Digit select uses next-state index and display so digito and anodo move together.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = disp_d[4*i +: 4];
`ifdef DISPLAY_BLANK_EN
         above_zero = above_zero && (nib == 4'h0);
         if (IW'(i) == idx_d) digito_d = (above_zero && (i != 0)) ? 4'hF : nib;
`else
         if (IW'(i) == idx_d) digito_d = nib;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= OCIOSO;
         shift_q   <= '0;
         acc_q     <= '0;
         iter_q    <= '0;
         ovf_q     <= 1'b0;
         estouro_q <= 1'b0;
         disp_q    <= '0;
         presc_q   <= '0;
         idx_q     <= '0;
         digito_q  <= 4'h0;
         anodo_q   <= ~(DIGITS'(1));
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         acc_q     <= acc_d;
         iter_q    <= iter_d;
         ovf_q     <= ovf_d;
         estouro_q <= estouro_d;
         disp_q    <= disp_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         digito_q  <= digito_d;
         anodo_q   <= anodo_d;
      end
   end

   assign ocupado = (state_q != OCIOSO);
   assign estouro = estouro_q;
   assign digito  = digito_q;
   assign anodo   = anodo_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: vector table, hand sequences and random loads
// compared against a decimal-arithmetic reference model.
module tb_display_scan_controller;

   localparam int DIGITS = 4;
   localparam int WIDTH  = 16;
   localparam int DIV    = 4;
   localparam int LIMIT  = 10000;

   logic              clock;
   logic              reset_n;
   logic [WIDTH-1:0]  valor;
   logic              carregar;
   logic              ocupado;
   logic              estouro;
   logic [3:0]        digito;
   logic [DIGITS-1:0] anodo;

   int errors = 0;
   int checks = 0;
   int cyc;
   int model_val = 0;
   bit model_ovf = 1'b0;

   display_scan_controller #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DIV(DIV)) dut (
      .clock(clock), .reset_n(reset_n), .valor(valor), .carregar(carregar),
      .ocupado(ocupado), .estouro(estouro), .digito(digito), .anodo(anodo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Edges seen since reset release; the active digit is cyc/DIV mod DIGITS.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   typedef struct {
      int          value;
      logic [15:0] digits;
      bit          ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int exp_nib(input int v, input int i);
      int p;
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      if (v >= LIMIT) return 9;
`ifdef DISPLAY_BLANK_EN
      if (i > 0 && v < p) return 15;
`endif
      return (v / p) % 10;
   endfunction

   task automatic scan_check();
      int idx;
      idx = (cyc / DIV) % DIGITS;
      check("scan_anodo", anodo, 4'(~(4'b0001 << idx)));
      check("scan_digito", digito, exp_nib(model_val, idx));
      check("scan_estouro", estouro, model_ovf);
   endtask

   task automatic check_reset_outputs();
      check("rst_ocupado", ocupado, 0);
      check("rst_estouro", estouro, 0);
      check("rst_anodo", anodo, 4'b1110);
      check("rst_digito", digito, 0);
   endtask

   // Load v; optionally pulse a second load at conversion cycle inj_at, or reset at cycle abort_at.
   task automatic do_load(input int v, input int inj_at, input int inj_val, input int abort_at);
      int hi;
      bit aborted;
      hi = 0;
      aborted = 1'b0;
      @(negedge clock);
      scan_check();
      valor = WIDTH'(v);
      carregar = 1'b1;
      @(negedge clock);
      carregar = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) @(negedge clock);
         if (abort_at >= 0 && k == abort_at) begin
            reset_n = 1'b0;
            #1;
            check_reset_outputs();
            model_val = 0;
            model_ovf = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (!ocupado) break;
         hi++;
         scan_check();
         if (k == inj_at) begin
            valor = WIDTH'(inj_val);
            carregar = 1'b1;
         end else begin
            carregar = 1'b0;
         end
      end
      carregar = 1'b0;
      if (!aborted) begin
         check("busy_len", hi, WIDTH + 1);
         model_val = v;
         model_ovf = (v >= LIMIT);
         scan_check();
      end
      for (int k = 0; k < DIGITS * DIV; k++) begin
         @(negedge clock);
         scan_check();
      end
   endtask

   task automatic check_table(input vec_t vec);
      bit found;
      logic [15:0] d;
      d = vec.digits;
      for (int i = 0; i < DIGITS; i++) begin
         found = 1'b0;
         for (int t = 0; t < DIGITS * DIV + 2; t++) begin
            @(negedge clock);
            if (anodo == 4'(~(4'b0001 << i))) begin
               found = 1'b1;
               break;
            end
         end
         check("tbl_digit_seen", found, 1);
         if (found) check("tbl_digito", digito, d[4*i +: 4]);
      end
      check("tbl_estouro", estouro, vec.ovf);
   endtask

   vec_t tbl[10];
   logic [3:0] seq[4];

   initial begin
      reset_n  = 1'b1;
      valor    = '0;
      carregar = 1'b0;

      tbl[0] = '{1234,  16'h1234, 1'b0};
`ifdef DISPLAY_BLANK_EN
      tbl[1] = '{7,     16'hFFF7, 1'b0};
      tbl[2] = '{0,     16'hFFF0, 1'b0};
      tbl[6] = '{50,    16'hFF50, 1'b0};
      tbl[9] = '{305,   16'hF305, 1'b0};
`else
      tbl[1] = '{7,     16'h0007, 1'b0};
      tbl[2] = '{0,     16'h0000, 1'b0};
      tbl[6] = '{50,    16'h0050, 1'b0};
      tbl[9] = '{305,   16'h0305, 1'b0};
`endif
      tbl[3] = '{12345, 16'h9999, 1'b1};
      tbl[4] = '{9999,  16'h9999, 1'b0};
      tbl[5] = '{1000,  16'h1000, 1'b0};
      tbl[7] = '{10000, 16'h9999, 1'b1};
      tbl[8] = '{65535, 16'h9999, 1'b1};
      seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      // Power-on reset, then the scan sequence with each digit held DIV cycles.
      #2 reset_n = 1'b0;
      #1 check_reset_outputs();
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clock);
         check("rst_seq_anodo", anodo, seq[(k / DIV) % DIGITS]);
         scan_check();
      end

      // Reset asserted mid-cycle takes effect immediately.
      do_load(1234, -1, 0, -1);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs();
      model_val = 0;
      model_ovf = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;

      for (int n = 0; n < 10; n++) begin
         do_load(tbl[n].value, -1, 0, -1);
         check_table(tbl[n]);
      end

      // A load request during conversion is dropped; one after ocupado falls is taken.
      do_load(1234, 5, 42, -1);
      check_table(tbl[0]);
      do_load(42, -1, 0, -1);

      // Reset mid-conversion clears the display; the next load converts normally.
      do_load(9999, -1, 0, -1);
      do_load(5678, -1, 0, 8);
      do_load(5678, -1, 0, -1);

      for (int n = 0; n < 24; n++) begin
         int v;
         v = (n % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9999));
         do_load(v, -1, 0, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
